// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder that adds one CHUNK-bit slice per stage and registers the slice carry.
// Optional feature macro ADDER_SUB_EN: adds the sub port (A - B - cin, cout reports borrow).
module pipe_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a multiple of CHUNK");
   end

   // valid/ready: a transfer happens on any cycle where valid and ready are both high.
   // All stages move together whenever the output slot is empty or being drained.
   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   always_comb begin
`ifdef ADDER_SUB_EN
      b_eff = sub ? ~b : b;
      c0    = sub ? ~cin : cin;
`else
      b_eff = b;
      c0    = cin;
`endif
   end

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int SW = (k + 1) * CHUNK;   // result bits known after this stage
      localparam int RW = WIDTH - SW;        // operand bits still waiting to be added

      logic [RW+CHUNK-1:0] oa;
      logic [RW+CHUNK-1:0] ob;
      logic                ci;
      logic                vi;
`ifdef ADDER_SUB_EN
      logic                subi;
`endif
      logic [CHUNK:0]      ch;
      logic [SW-1:0]       s_d;
      logic [SW-1:0]       s_q;
      logic                v_d;
      logic                v_q;

      if (k == 0) begin : g_src
         always_comb begin
            oa = a;
            ob = b_eff;
            ci = c0;
            vi = in_valid;
`ifdef ADDER_SUB_EN
            subi = sub;
`endif
         end
         always_comb s_d = ch[CHUNK-1:0];
      end else begin : g_src
         always_comb begin
            oa = g_stg[k-1].g_mid.a_q;
            ob = g_stg[k-1].g_mid.b_q;
            ci = g_stg[k-1].g_mid.c_q;
            vi = g_stg[k-1].v_q;
`ifdef ADDER_SUB_EN
            subi = g_stg[k-1].g_mid.sub_q;
`endif
         end
         // new slice lands above the slices already summed
         always_comb s_d = {ch[CHUNK-1:0], g_stg[k-1].s_q};
      end

      always_comb begin
         ch  = {1'b0, oa[CHUNK-1:0]} + {1'b0, ob[CHUNK-1:0]} + {{CHUNK{1'b0}}, ci};
         v_d = vi;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_d;
            if (vi) s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [RW-1:0] a_d;
         logic [RW-1:0] a_q;
         logic [RW-1:0] b_d;
         logic [RW-1:0] b_q;
         logic          c_d;
         logic          c_q;
`ifdef ADDER_SUB_EN
         logic          sub_d;
         logic          sub_q;
`endif

         always_comb begin
            a_d = oa[RW+CHUNK-1:CHUNK];
            b_d = ob[RW+CHUNK-1:CHUNK];
            c_d = ch[CHUNK];
`ifdef ADDER_SUB_EN
            sub_d = subi;
`endif
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
               c_q <= 1'b0;
`ifdef ADDER_SUB_EN
               sub_q <= 1'b0;
`endif
            end else if (adv && vi) begin
               a_q <= a_d;
               b_q <= b_d;
               c_q <= c_d;
`ifdef ADDER_SUB_EN
               sub_q <= sub_d;
`endif
            end
         end
      end else begin : g_last
         logic cout_d;
         logic cout_q;
         logic ovf_d;
         logic ovf_q;
         logic zero_d;
         logic zero_q;

         // carry into the MSB is recovered from the MSB sum bit and its operands
         always_comb begin
`ifdef ADDER_SUB_EN
            cout_d = ch[CHUNK] ^ subi;
`else
            cout_d = ch[CHUNK];
`endif
            ovf_d  = oa[CHUNK-1] ^ ob[CHUNK-1] ^ ch[CHUNK-1] ^ ch[CHUNK];
            zero_d = (s_d == '0);
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv && vi) begin
               cout_q <= cout_d;
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_q;
   assign sum       = g_stg[STAGES-1].s_q;
   assign cout      = g_stg[STAGES-1].g_last.cout_q;
   assign ovf       = g_stg[STAGES-1].g_last.ovf_q;
   assign zero      = g_stg[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a 32/8 instance (latency 4) and an 8/8 instance (latency 1),
// scoreboarded against an arithmetic reference model built on signed/unsigned integers.
module tb_pipe_adder;
   localparam int W = 32;
   localparam int C = 8;
   localparam int STG = W / C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, cin, sub_i, out_valid, out_ready, cout, ovf, zero;
   logic [W-1:0] a, b, sum;
   logic         s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_cout, s_ovf, s_zero;
   logic [7:0]   s_a, s_b, s_sum;

   int errors = 0;
   int checks = 0;
   logic [34:0] exp_q[$];
   logic [10:0] exp8_q[$];
   logic [34:0] mon_e;
   logic [10:0] mon_e8;
   int cyc_cnt = 0;

   pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
      .sub(sub_i),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf), .zero(zero)
   );

   pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin),
`ifdef ADDER_SUB_EN
      .sub(s_sub),
`endif
      .out_valid(s_out_valid), .out_ready(1'b1), .sum(s_sum),
      .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
   );

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference: returns {cout, ovf, zero, sum} for a w-bit add or subtract.
   function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
      longint mask, half, ux, uy, c, sx, sy, ur, sr;
      logic [31:0] s;
      logic co, ov;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ux = longint'({32'd0, x}) & mask;
      uy = longint'({32'd0, y}) & mask;
      c  = ci ? 1 : 0;
      sx = (ux >= half) ? ux - 2 * half : ux;
      sy = (uy >= half) ? uy - 2 * half : uy;
      if (sb) begin
         ur = ux - uy - c;
         sr = sx - sy - c;
         co = (ur < 0);
      end else begin
         ur = ux + uy + c;
         sr = sx + sy + c;
         co = (ur > mask);
      end
      ov = (sr >= half) || (sr < -half);
      s  = 32'(ur & mask);
      return {co, ov, (s == 32'd0), s};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitors: pop one expected result per consumed output.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_out: observed sum=%0h expected no output", sum);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result32", {29'd0, cout, ovf, zero, sum}, 64'(mon_e));
         end
      end
      if (rst_n === 1'b1 && s_out_valid === 1'b1) begin
         if (exp8_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_out8: observed sum=%0h expected no output", s_sum);
         end else begin
            mon_e8 = exp8_q.pop_front();
            chk("result8", {53'd0, s_cout, s_ovf, s_zero, s_sum}, 64'(mon_e8));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Drive one op on the 32-bit DUT; returns 1 time unit after the accepting edge.
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
      logic acc;
      int t;
      a = x; b = y; cin = ci; sub_i = sb; in_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
         acc = (in_ready === 1'b1);
         if (acc) exp_q.push_back(model(W, x, y, ci, sb));
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed in_ready=%b expected 1", in_ready);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic lat_op(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                         input logic [34:0] spec_res, input string tag);
      int n;
      drain();
      send(x, y, ci, sb);
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, STG);
      chk({tag, "_value"}, {29'd0, cout, ovf, zero, sum}, 64'(spec_res));
   endtask

   initial begin
      int n_sent, stall_left, last_acc, vcount, c0;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_flags", {cout, ovf, zero}, 0);
      chk("reset_out_valid8", s_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed corners with spec-given results
      lat_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0}, "wrap");
      lat_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000}, "ovf_pos");
      lat_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 32'h0}, "ovf_neg");
      lat_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0}, "cin_wrap");
      lat_op(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0100_0000}, "chunk_carry");
      lat_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h2345_678A}, "plain");
`ifdef ADDER_SUB_EN
      lat_op(32'd5, 32'd7, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_borrow");
      lat_op(32'd7, 32'd5, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'h1}, "sub_bin");
      lat_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF}, "sub_ovf");
`endif
      drain();

      // Back-to-back random stream: one accept per cycle
      c0 = cyc_cnt;
      for (int i = 0; i < 30; i++) begin
         logic sb;
         sb = 1'b0;
`ifdef ADDER_SUB_EN
         sb = 1'($urandom_range(0, 1));
`endif
         send($urandom, (i % 5 == 0) ? ~32'($urandom_range(0, 3)) : $urandom,
              1'($urandom_range(0, 1)), sb);
      end
      chk("throughput", cyc_cnt - c0, 30);
      drain();

      // Six consecutive ops with a three-cycle stall at the first output
      n_sent = 0; stall_left = -1; last_acc = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (out_valid === 1'b1 && stall_left < 0) stall_left = 3;
         out_ready = !(stall_left > 0);
         #1;
         if (stall_left > 0) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum_hold", sum, exp_q[0][31:0]);
         end else begin
            chk("run_in_ready", in_ready, 1);
         end
         if (n_sent < 6) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub_i = 1'b0;
            in_valid = 1'b1;
            if (in_ready === 1'b1) begin
               exp_q.push_back(model(W, a, b, cin, 1'b0));
               n_sent++;
               last_acc = cyc;
            end
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (stall_left > 0) stall_left--;
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      chk("stall_all_sent", n_sent, 6);
      chk("stall_last_accept", last_acc, 8);
      drain();

      // Asynchronous reset with several ops in flight
      for (int i = 0; i < 5; i++) send(32'h100 + i, 32'h0001_0000, 1'b0, 1'b0);
      chk("pre_reset_out_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_sum", sum, 0);
      chk("async_rst_in_ready", in_ready, 1);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) vcount++;
      end
      chk("no_stale_after_reset", vcount, 0);
      lat_op(32'hCAFE_0000, 32'h0000_BABE, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'hCAFE_BABE}, "post_reset");
      drain();

      // Degenerate 8/8 instance: latency 1, then a dense sweep
      s_a = 8'hFF; s_b = 8'h01; s_cin = 1'b0; s_sub = 1'b0; s_in_valid = 1'b1;
      exp8_q.push_back({3'b101, 8'h00});
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      chk("lat8_out_valid", s_out_valid, 1);
      chk("lat8_value", {s_cout, s_ovf, s_zero, s_sum}, {3'b101, 8'h00});
      @(posedge clk); #1;
      for (int ai = 0; ai < 256; ai++) begin
         for (int bi = 0; bi < 5; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               logic [34:0] r;
               logic [7:0] bv [5];
               bv[0] = 8'h00; bv[1] = 8'h01; bv[2] = 8'h7F; bv[3] = 8'h80; bv[4] = 8'hFF;
               s_a = 8'(ai); s_b = bv[bi]; s_cin = 1'(ci); s_sub = 1'b0;
`ifdef ADDER_SUB_EN
               s_sub = 1'(ai[0] ^ ci[0]);
`endif
               s_in_valid = 1'b1;
               r = model(8, {24'd0, s_a}, {24'd0, s_b}, s_cin, s_sub);
               exp8_q.push_back({r[34:32], r[7:0]});
               @(posedge clk); #1;
            end
         end
      end
      for (int i = 0; i < 500; i++) begin
         logic [34:0] r;
         s_a = 8'($urandom); s_b = 8'($urandom); s_cin = 1'($urandom_range(0, 1)); s_sub = 1'b0;
`ifdef ADDER_SUB_EN
         s_sub = 1'($urandom_range(0, 1));
`endif
         r = model(8, {24'd0, s_a}, {24'd0, s_b}, s_cin, s_sub);
         exp8_q.push_back({r[34:32], r[7:0]});
         @(posedge clk); #1;
      end
      s_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("drain8_empty", exp8_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
